uart_mult_sequencer: RTL
========================

Name: uart_mult_sequencer

Overview:
Control FSM between the UART byte receiver, the 8-bit multiplier and the UART byte transmitter.
- Collects two operand bytes (A, then B) from the receiver and starts one multiply.
- Waits for the product, then sends it back over the transmitter, high byte first.
- Enforces an inter-byte timeout and flags dropped bytes.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; used only to derive TIMEOUT_CYCLES.
- TIMEOUT_MS, 500, maximum gap between A and B before the frame is discarded.
- TIMEOUT_CYCLES, CLK_FREQ/1000*TIMEOUT_MS, derived; timer width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a newly received byte.
- rx_data  in  8  received byte.
- mul_start  out  1  one-cycle pulse that starts the multiplier.
- mul_a  out  8  operand A; held stable from mul_start until mul_done.
- mul_b  out  8  operand B; held stable from mul_start until mul_done.
- mul_done  in  1  one-cycle pulse: mul_product is valid.
- mul_product  in  16  multiplier result.
- tx_start  out  1  one-cycle pulse that starts the transmitter.
- tx_data  out  8  byte to send; stable while tx_start is high.
- tx_busy  in  1  transmitter busy; must be high no later than the cycle after tx_start.
- busy  out  1  high in every state except GET_A.
- frame_done  out  1  one-cycle pulse when the last byte's transmission completes.
- err_timeout  out  1  one-cycle pulse when a frame is discarded on timeout.
- rx_overrun  out  1  sticky; set when rx_valid arrives outside GET_A/GET_B.

Behaviour:
- Reset (every clk edge with reset=1): state=GET_A; timer=0; operand/product registers=0. All outputs 0, including rx_overrun.
- States: GET_A, GET_B, MUL_GO, MUL_WAIT, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
- GET_A: on rx_valid, latch A <= rx_data, clear timer, go to GET_B.
- GET_B: timer increments each cycle.
  - On rx_valid: latch B, go to MUL_GO.
  - Else if timer == TIMEOUT_CYCLES-1: err_timeout=1 for one cycle, go to GET_A; A is discarded.
  - rx_valid in the same cycle as expiry: the byte wins, no error.
- MUL_GO: mul_start=1 for exactly one cycle, go to MUL_WAIT. Latency from B's rx_valid to mul_start is 1 cycle.
- MUL_WAIT: on mul_done, latch product P <= mul_product, go to SEND_HI. No timeout in this state.
- SEND_HI: waits while tx_busy=1. When tx_busy=0: tx_start=1, tx_data=P[15:8], go to WAIT_HI.
- WAIT_HI: ignore tx_busy on the first cycle (guard). Afterwards, tx_busy=0 goes to SEND_LO.
- SEND_LO and WAIT_LO: same as SEND_HI and WAIT_HI, sending P[7:0].
- WAIT_LO exit (tx_busy=0 after guard): frame_done=1 for one cycle, go to GET_A.
- tx_data holds its last driven value outside SEND_* states.
- rx_valid in MUL_GO through WAIT_LO: byte dropped, rx_overrun <= 1. rx_overrun stays set until reset.
- Reset mid-frame: abort immediately. No further mul_start or tx_start; the partial frame is lost.
- Arithmetic: timer saturates at TIMEOUT_CYCLES-1. No other arithmetic.

Optional Feature:
- UART_SEQ_CHECKSUM_EN defined:
  - Adds states SEND_CK and WAIT_CK after WAIT_LO.
  - Sends a third byte P[15:8] ^ P[7:0] with the same start/guard/wait rules.
  - frame_done fires after WAIT_CK.
- Undefined: two-byte response; checksum states and logic are absent.

Decomposition:
- Package uart_seq_pkg holds the state enum (width 4 to cover the checksum states) and the byte/product width constants (8, 16).
- One sub-module: seq_timeout_timer (clear, enable, expired output, parameter TIMEOUT_CYCLES), used in GET_B.

Test Plan:
- Basic multiply: rx 0x0C, then 0x0B within the timeout; mul model returns 0x0084 three cycles after mul_start.
  - Expect: mul_start one cycle after B; mul_a=0x0C, mul_b=0x0B; tx bytes 0x00 then 0x84; frame_done once.
- Maximum operands: rx 0xFF, 0xFF; product 0xFE01 -> tx 0xFE then 0x01.
- Timeout (TIMEOUT_CYCLES=50 in the bench):
  - rx 0x05 only -> err_timeout pulse exactly 50 cycles after the GET_B entry; no mul_start.
  - Then rx 0x02, 0x03 -> tx 0x00, 0x06.
- Overrun and back-pressure: rx 0x11 during MUL_WAIT -> rx_overrun=1 and held; product unaffected. tx_busy held high for 20 cycles before SEND_HI -> tx_start delayed until tx_busy=0.
- Reset mid-send: reset asserted in WAIT_HI -> next cycle all outputs 0, state GET_A, no second tx_start. A new frame 0x03, 0x04 -> tx 0x00, 0x0C.
- With UART_SEQ_CHECKSUM_EN: rx 0xFF, 0xFF -> tx 0xFE, 0x01, 0xFF; frame_done only after the third byte.

Source files
------------

// File: rtl/uart_mult_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_seq_pkg
// Purpose  : Shared types and widths for the UART multiply sequencer.
//            The state encoding is 4 bits wide so the optional checksum
//            states fit without changing the type.
// Revision : 1.0  initial release
// ============================================================================
package uart_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [3:0] {
    ST_GET_A    = 4'd0,
    ST_GET_B    = 4'd1,
    ST_MUL_GO   = 4'd2,
    ST_MUL_WAIT = 4'd3,
    ST_SEND_HI  = 4'd4,
    ST_WAIT_HI  = 4'd5,
    ST_SEND_LO  = 4'd6,
    ST_WAIT_LO  = 4'd7,
    ST_SEND_CK  = 4'd8,
    ST_WAIT_CK  = 4'd9
  } seq_state_e;

  // XOR of the two product bytes, sent as the optional third byte.
  function automatic logic [BYTE_W-1:0] checksum_byte(input logic [PROD_W-1:0] p);
    return p[PROD_W-1:BYTE_W] ^ p[BYTE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mult_sequencer_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_timeout_timer
// Purpose  : Inter-byte gap counter. Counts while enabled, saturates at
//            TIMEOUT_CYCLES-1 and flags expiry at that count.
// Revision : 1.0  initial release
// ============================================================================
module seq_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int             CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise step up until the last count and hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST_COUNT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/uart_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_mult_sequencer
// Purpose  : Control FSM between the UART receiver, an 8-bit multiplier and
//            the UART transmitter. Collects operands A and B, starts one
//            multiply, returns the product high byte first, discards a
//            frame whose B byte arrives too late and flags dropped bytes.
// Options  : UART_SEQ_CHECKSUM_EN - append a third byte (P[15:8] ^ P[7:0]).
// Revision : 1.0  initial release
// ============================================================================
module uart_mult_sequencer
  import uart_seq_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TIMEOUT_MS = 500
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  output logic              mul_start_o,
  output logic [BYTE_W-1:0] mul_a_o,
  output logic [BYTE_W-1:0] mul_b_o,
  input  logic              mul_done_i,
  input  logic [PROD_W-1:0] mul_product_i,
  output logic              tx_start_o,
  output logic [BYTE_W-1:0] tx_data_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_timeout_o,
  output logic              rx_overrun_o
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;

  seq_state_e        state_q;
  logic [BYTE_W-1:0] a_q;
  logic [BYTE_W-1:0] b_q;
  logic [PROD_W-1:0] p_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              mul_start_q;
  logic              tx_start_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              err_timeout_q;
  logic              rx_overrun_q;
  logic              guard_q;

  logic              w_timer_clear;
  logic              w_timer_en;
  logic              w_expired;

  // Timer is held at zero while idle so GET_B always starts counting from 0.
  assign w_timer_clear = (state_q == ST_GET_A);
  assign w_timer_en    = (state_q == ST_GET_B);

  seq_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (w_timer_clear),
    .enable_i  (w_timer_en),
    .expired_o (w_expired)
  );

  // Sequencer FSM; all outputs are registered and pulses default low.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_GET_A;
      a_q           <= '0;
      b_q           <= '0;
      p_q           <= '0;
      tx_data_q     <= '0;
      mul_start_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      guard_q       <= 1'b0;
    end else begin
      mul_start_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;

      // Any byte arriving while a frame is being processed is lost.
      if (rx_valid_i && (state_q != ST_GET_A) && (state_q != ST_GET_B)) begin
        rx_overrun_q <= 1'b1;
      end

      case (state_q)
        ST_GET_A: begin
          if (rx_valid_i) begin
            a_q     <= rx_data_i;
            busy_q  <= 1'b1;
            state_q <= ST_GET_B;
          end
        end

        // A byte arriving on the expiry cycle still completes the frame.
        ST_GET_B: begin
          if (rx_valid_i) begin
            b_q         <= rx_data_i;
            mul_start_q <= 1'b1;
            state_q     <= ST_MUL_GO;
          end else if (w_expired) begin
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_GET_A;
          end
        end

        ST_MUL_GO: begin
          state_q <= ST_MUL_WAIT;
        end

        ST_MUL_WAIT: begin
          if (mul_done_i) begin
            p_q     <= mul_product_i;
            state_q <= ST_SEND_HI;
          end
        end

        ST_SEND_HI: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= p_q[PROD_W-1:BYTE_W];
            guard_q    <= 1'b1;
            state_q    <= ST_WAIT_HI;
          end
        end

        // First cycle skipped: the transmitter may not have raised busy yet.
        ST_WAIT_HI: begin
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (!tx_busy_i) begin
            state_q <= ST_SEND_LO;
          end
        end

        ST_SEND_LO: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= p_q[BYTE_W-1:0];
            guard_q    <= 1'b1;
            state_q    <= ST_WAIT_LO;
          end
        end

        ST_WAIT_LO: begin
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (!tx_busy_i) begin
`ifdef UART_SEQ_CHECKSUM_EN
            state_q <= ST_SEND_CK;
`else
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_GET_A;
`endif
          end
        end

`ifdef UART_SEQ_CHECKSUM_EN
        ST_SEND_CK: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= checksum_byte(p_q);
            guard_q    <= 1'b1;
            state_q    <= ST_WAIT_CK;
          end
        end

        ST_WAIT_CK: begin
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (!tx_busy_i) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_GET_A;
          end
        end
`endif

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_GET_A;
        end
      endcase
    end
  end

  assign mul_start_o   = mul_start_q;
  assign mul_a_o       = a_q;
  assign mul_b_o       = b_q;
  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;
  assign err_timeout_o = err_timeout_q;
  assign rx_overrun_o  = rx_overrun_q;

endmodule
`default_nettype wire
